// File: rtl/alarm_mode_controller.sv
// ---------------------------------------------------------------------------
// alarm_mode_controller
//
// Top-level sequencer for the alarm clock. Owns the running BCD time of day
// and the stored alarm time, shares the debounced buttons between the time
// editor and the alarm editor, loads confirmed edit values, detects the alarm
// match and times the ring period. Feeds the 7-segment display driver.
//
// Ports:
//   clk, rst_n              system clock, asynchronous active-low reset
//   tick_1hz                one-cycle pulse once per second
//   switch_set_time         level, request time edit (highest priority)
//   switch_set_alarm        level, request alarm edit
//   switch_alarm_enable     level, alarm armed when 1
//   button_*, confirm_pulse debounced single-cycle pulses
//   time_edit_value         BCD HHMMSS from the time editor
//   alarm_edit_value        BCD HHMMSS from the alarm editor
//   time_buttons            {left,right,increase,decrease} to the time editor
//   alarm_buttons           same, to the alarm editor
//   current_time            running BCD time
//   alarm_time              stored BCD alarm
//   time_display            value for the display driver
//   mode                    00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RING
//   alarm_ringing           1 while in RING
// ---------------------------------------------------------------------------
module alarm_mode_controller #(
    parameter int unsigned RING_SECONDS = 60,
    parameter logic [23:0] ALARM_RESET  = 24'h070000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        switch_set_time,
    input  logic        switch_set_alarm,
    input  logic        switch_alarm_enable,
    input  logic        button_left,
    input  logic        button_right,
    input  logic        button_increase,
    input  logic        button_decrease,
    input  logic        confirm_pulse,
    input  logic [23:0] time_edit_value,
    input  logic [23:0] alarm_edit_value,
    output logic [3:0]  time_buttons,
    output logic [3:0]  alarm_buttons,
    output logic [23:0] current_time,
    output logic [23:0] alarm_time,
    output logic [23:0] time_display,
    output logic [1:0]  mode,
    output logic        alarm_ringing
);

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_TIME  = 2'b01;
    localparam logic [1:0] MODE_SET_ALARM = 2'b10;
    localparam logic [1:0] MODE_RING      = 2'b11;

    localparam logic [7:0] RING_LIMIT = 8'(RING_SECONDS);

    // Advance a BCD HHMMSS value by one second, wrapping 23:59:59 to 00:00:00.
    function automatic logic [23:0] bcd_increment(input logic [23:0] t);
        logic [3:0] hl, hr, ml, mr, sl, sr;
        {hl, hr, ml, mr, sl, sr} = t;
        if (sr != 4'd9) begin
            sr = sr + 4'd1;
        end else begin
            sr = 4'd0;
            if (sl != 4'd5) begin
                sl = sl + 4'd1;
            end else begin
                sl = 4'd0;
                if (mr != 4'd9) begin
                    mr = mr + 4'd1;
                end else begin
                    mr = 4'd0;
                    if (ml != 4'd5) begin
                        ml = ml + 4'd1;
                    end else begin
                        ml = 4'd0;
                        if (hl == 4'd2 && hr == 4'd3) begin
                            hl = 4'd0;
                            hr = 4'd0;
                        end else if (hr == 4'd9) begin
                            hr = 4'd0;
                            hl = hl + 4'd1;
                        end else begin
                            hr = hr + 4'd1;
                        end
                    end
                end
            end
        end
        return {hl, hr, ml, mr, sl, sr};
    endfunction

    // A legal time of day: hours 00..23, tens of minutes/seconds 0..5,
    // every digit 0..9.
    function automatic logic bcd_valid(input logic [23:0] t);
        logic [3:0] hl, hr, ml, mr, sl, sr;
        {hl, hr, ml, mr, sl, sr} = t;
        return (hl <= 4'd2) && (hr <= 4'd9) && !(hl == 4'd2 && hr > 4'd3) &&
               (ml <= 4'd5) && (mr <= 4'd9) && (sl <= 4'd5) && (sr <= 4'd9);
    endfunction

    logic [3:0]  buttons;
    logic [23:0] time_next;
    logic [7:0]  ring_count;
    logic [1:0]  mode_next;
    logic        any_press;
    logic        alarm_hit;
    logic        ring_done;

    assign buttons   = {button_left, button_right, button_increase, button_decrease};
    assign time_next = bcd_increment(current_time);
    assign any_press = (|buttons) || confirm_pulse;

    // Only a tick-driven increment in RUN can start the alarm; loads from the
    // editors never do.
    assign alarm_hit = (mode == MODE_RUN) && switch_alarm_enable && tick_1hz &&
                       (time_next == alarm_time);
    assign ring_done = tick_1hz && ((ring_count + 8'd1) == RING_LIMIT);

    // Next mode: the two edit switches dominate; otherwise RING holds until
    // timeout, any user activity or disarm, and RUN enters RING on a match.
    always_comb begin
        mode_next = MODE_RUN;
        if (switch_set_time) begin
            mode_next = MODE_SET_TIME;
        end else if (switch_set_alarm) begin
            mode_next = MODE_SET_ALARM;
        end else if (mode == MODE_RING) begin
            if (any_press || !switch_alarm_enable || ring_done) begin
                mode_next = MODE_RUN;
            end else begin
                mode_next = MODE_RING;
            end
        end else if (alarm_hit) begin
            mode_next = MODE_RING;
        end
    end

    // Mode register and ring timer. The counter sits at zero outside RING so
    // it is already cleared on the edge that enters RING.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode          <= MODE_RUN;
            alarm_ringing <= 1'b0;
            ring_count    <= 8'd0;
        end else begin
            mode          <= mode_next;
            alarm_ringing <= (mode_next == MODE_RING);
            if (mode != MODE_RING) begin
                ring_count <= 8'd0;
            end else if (tick_1hz) begin
                ring_count <= ring_count + 8'd1;
            end
        end
    end

    // Timekeeping and confirmed loads. A valid confirm in SET_TIME wins over a
    // coincident tick; the clock is otherwise frozen while being edited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_time <= 24'h000000;
            alarm_time   <= ALARM_RESET;
        end else begin
            if (mode == MODE_SET_TIME) begin
                if (confirm_pulse && bcd_valid(time_edit_value)) begin
                    current_time <= time_edit_value;
                end
            end else if (tick_1hz) begin
                current_time <= time_next;
            end
            if (mode == MODE_SET_ALARM && confirm_pulse && bcd_valid(alarm_edit_value)) begin
                alarm_time <= alarm_edit_value;
            end
        end
    end

    // Button routing and display select follow the registered mode, so at
    // most one editor ever sees buttons and RING routes to neither.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_buttons  <= 4'd0;
            alarm_buttons <= 4'd0;
            time_display  <= 24'h000000;
        end else begin
            time_buttons  <= (mode == MODE_SET_TIME)  ? buttons : 4'd0;
            alarm_buttons <= (mode == MODE_SET_ALARM) ? buttons : 4'd0;
            case (mode)
                MODE_SET_TIME:  time_display <= time_edit_value;
                MODE_SET_ALARM: time_display <= alarm_edit_value;
                default:        time_display <= current_time;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_mode_controller.sv
// ---------------------------------------------------------------------------
// tb_alarm_mode_controller
//
// Directed bench for alarm_mode_controller (RING_SECONDS = 3). Stimulus code
// pushes hand-computed expectations, tagged with the cycle at which they are
// due, into a scoreboard queue; a monitor on the falling clock edge pops due
// entries and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_alarm_mode_controller;

    logic        clk;
    logic        rst_n;
    logic        tick_1hz;
    logic        switch_set_time;
    logic        switch_set_alarm;
    logic        switch_alarm_enable;
    logic        button_left, button_right, button_increase, button_decrease;
    logic        confirm_pulse;
    logic [23:0] time_edit_value;
    logic [23:0] alarm_edit_value;
    logic [3:0]  time_buttons;
    logic [3:0]  alarm_buttons;
    logic [23:0] current_time;
    logic [23:0] alarm_time;
    logic [23:0] time_display;
    logic [1:0]  mode;
    logic        alarm_ringing;

    alarm_mode_controller #(
        .RING_SECONDS (3),
        .ALARM_RESET  (24'h070000)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .tick_1hz            (tick_1hz),
        .switch_set_time     (switch_set_time),
        .switch_set_alarm    (switch_set_alarm),
        .switch_alarm_enable (switch_alarm_enable),
        .button_left         (button_left),
        .button_right        (button_right),
        .button_increase     (button_increase),
        .button_decrease     (button_decrease),
        .confirm_pulse       (confirm_pulse),
        .time_edit_value     (time_edit_value),
        .alarm_edit_value    (alarm_edit_value),
        .time_buttons        (time_buttons),
        .alarm_buttons       (alarm_buttons),
        .current_time        (current_time),
        .alarm_time          (alarm_time),
        .time_display        (time_display),
        .mode                (mode),
        .alarm_ringing       (alarm_ringing)
    );

    localparam int SEL_TIME  = 0;
    localparam int SEL_ALARM = 1;
    localparam int SEL_MODE  = 2;
    localparam int SEL_RING  = 3;
    localparam int SEL_TBTN  = 4;
    localparam int SEL_ABTN  = 5;
    localparam int SEL_DISP  = 6;

    typedef struct {
        int          due;
        string       name;
        int          sel;
        logic [23:0] value;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // 100 MHz-style bench clock; period only matters relative to the checks.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to schedule when each expectation is due.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] probe(input int sel);
        case (sel)
            SEL_TIME:  return current_time;
            SEL_ALARM: return alarm_time;
            SEL_MODE:  return {22'd0, mode};
            SEL_RING:  return {23'd0, alarm_ringing};
            SEL_TBTN:  return {20'd0, time_buttons};
            SEL_ABTN:  return {20'd0, alarm_buttons};
            default:   return time_display;
        endcase
    endfunction

    task automatic checkOutput(input string name, input int sel, input logic [23:0] value);
        logic [23:0] actual;
        actual = probe(sel);
        n_checks++;
        if (actual !== value) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, value);
        end
    endtask

    task automatic push_expect(input int k, input string name, input int sel, input logic [23:0] value);
        exp_t e;
        e.due   = cyc + k;
        e.name  = name;
        e.sel   = sel;
        e.value = value;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation that has come due, away from the
    // active edge.
    always @(negedge clk) begin
        for (int i = 0; i < sb.size(); ) begin
            if (sb[i].due <= cyc) begin
                checkOutput(sb[i].name, sb[i].sel, sb[i].value);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive single-cycle pulses for one clock, starting at a falling edge.
    task automatic applyStimulus(input logic [3:0] btn, input logic conf, input logic tk);
        {button_left, button_right, button_increase, button_decrease} = btn;
        confirm_pulse = conf;
        tick_1hz      = tk;
        @(negedge clk);
        {button_left, button_right, button_increase, button_decrease} = 4'd0;
        confirm_pulse = 1'b0;
        tick_1hz      = 1'b0;
    endtask

    // Store an alarm one second ahead of current_time, return to RUN and tick
    // into RING.
    task automatic arm_and_ring(input logic [23:0] alarm);
        switch_set_alarm = 1'b1;
        alarm_edit_value = alarm;
        idle(1);
        push_expect(1, "arm_alarm", SEL_ALARM, alarm);
        applyStimulus(4'd0, 1'b1, 1'b0);
        switch_set_alarm = 1'b0;
        idle(1);
        push_expect(1, "arm_ring_mode", SEL_MODE, 24'd3);
        push_expect(1, "arm_ring_time", SEL_TIME, alarm);
        applyStimulus(4'd0, 1'b0, 1'b1);
    endtask

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n               = 1'b0;
        tick_1hz            = 1'b0;
        switch_set_time     = 1'b0;
        switch_set_alarm    = 1'b0;
        switch_alarm_enable = 1'b0;
        {button_left, button_right, button_increase, button_decrease} = 4'd0;
        confirm_pulse       = 1'b0;
        time_edit_value     = 24'h000000;
        alarm_edit_value    = 24'h000000;

        // Reset values
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_expect(1, "rst_time",  SEL_TIME,  24'h000000);
        push_expect(1, "rst_alarm", SEL_ALARM, 24'h070000);
        push_expect(1, "rst_mode",  SEL_MODE,  24'd0);
        push_expect(1, "rst_ring",  SEL_RING,  24'd0);
        push_expect(1, "rst_tbtn",  SEL_TBTN,  24'd0);
        push_expect(1, "rst_abtn",  SEL_ABTN,  24'd0);
        push_expect(1, "rst_disp",  SEL_DISP,  24'h000000);
        idle(1);

        // One tick in RUN
        push_expect(1, "tick_time", SEL_TIME, 24'h000001);
        push_expect(1, "tick_mode", SEL_MODE, 24'd0);
        push_expect(2, "run_disp",  SEL_DISP, 24'h000001);
        applyStimulus(4'd0, 1'b0, 1'b1);
        idle(1);

        // Preload 23:59:59 and wrap to midnight
        switch_set_time = 1'b1;
        time_edit_value = 24'h235959;
        push_expect(1, "st_mode", SEL_MODE, 24'd1);
        push_expect(2, "st_disp", SEL_DISP, 24'h235959);
        idle(1);
        push_expect(1, "st_load", SEL_TIME, 24'h235959);
        applyStimulus(4'd0, 1'b1, 1'b0);
        switch_set_time = 1'b0;
        push_expect(1, "back_run", SEL_MODE, 24'd0);
        idle(1);
        push_expect(1, "wrap", SEL_TIME, 24'h000000);
        applyStimulus(4'd0, 1'b0, 1'b1);

        // Both switches: SET_TIME wins, buttons to the time editor only
        switch_set_time  = 1'b1;
        switch_set_alarm = 1'b1;
        push_expect(1, "both_mode", SEL_MODE, 24'd1);
        idle(1);
        push_expect(1, "tbtn_right", SEL_TBTN, 24'h4);
        push_expect(1, "abtn_right", SEL_ABTN, 24'h0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        push_expect(1, "tbtn_clear", SEL_TBTN, 24'h0);
        repeat (3) applyStimulus(4'd0, 1'b0, 1'b1);
        push_expect(1, "frozen", SEL_TIME, 24'h000000);
        idle(1);

        // SET_ALARM: load, buttons to the alarm editor, clock keeps running
        switch_set_time  = 1'b0;
        alarm_edit_value = 24'h063000;
        push_expect(1, "sa_mode", SEL_MODE, 24'd2);
        push_expect(2, "sa_disp", SEL_DISP, 24'h063000);
        idle(1);
        push_expect(1, "sa_load", SEL_ALARM, 24'h063000);
        applyStimulus(4'd0, 1'b1, 1'b0);
        push_expect(1, "abtn_left", SEL_ABTN, 24'h8);
        push_expect(1, "tbtn_left", SEL_TBTN, 24'h0);
        push_expect(1, "sa_tick",   SEL_TIME, 24'h000001);
        applyStimulus(4'b1000, 1'b0, 1'b1);

        // Invalid BCD rejected in SET_TIME; valid confirm beats a tick
        switch_set_alarm = 1'b0;
        switch_set_time  = 1'b1;
        time_edit_value  = 24'h245000;
        idle(1);
        push_expect(1, "rej_hour", SEL_TIME, 24'h000001);
        applyStimulus(4'd0, 1'b1, 1'b0);
        time_edit_value = 24'h126000;
        push_expect(1, "rej_min", SEL_TIME, 24'h000001);
        applyStimulus(4'd0, 1'b1, 1'b0);
        time_edit_value = 24'h00005A;
        push_expect(1, "rej_digit", SEL_TIME, 24'h000001);
        applyStimulus(4'd0, 1'b1, 1'b0);
        time_edit_value = 24'h065959;
        push_expect(1, "load_and_tick", SEL_TIME, 24'h065959);
        applyStimulus(4'd0, 1'b1, 1'b1);

        // Alarm back to 07:00:00, then an invalid alarm is ignored
        switch_set_time  = 1'b0;
        switch_set_alarm = 1'b1;
        alarm_edit_value = 24'h070000;
        idle(1);
        push_expect(1, "alarm_0700", SEL_ALARM, 24'h070000);
        applyStimulus(4'd0, 1'b1, 1'b0);
        alarm_edit_value = 24'h075960;
        push_expect(1, "rej_alarm", SEL_ALARM, 24'h070000);
        applyStimulus(4'd0, 1'b1, 1'b0);

        // Match at 07:00:00, then self-cancel after three ticks
        switch_set_alarm    = 1'b0;
        switch_alarm_enable = 1'b1;
        idle(1);
        push_expect(1, "ring_time", SEL_TIME, 24'h070000);
        push_expect(1, "ring_mode", SEL_MODE, 24'd3);
        push_expect(1, "ring_flag", SEL_RING, 24'd1);
        push_expect(2, "ring_disp", SEL_DISP, 24'h070000);
        applyStimulus(4'd0, 1'b0, 1'b1);
        push_expect(1, "ring1_mode", SEL_MODE, 24'd3);
        applyStimulus(4'd0, 1'b0, 1'b1);
        push_expect(1, "ring2_mode", SEL_MODE, 24'd3);
        applyStimulus(4'd0, 1'b0, 1'b1);
        push_expect(1, "ring_end_mode", SEL_MODE, 24'd0);
        push_expect(1, "ring_end_flag", SEL_RING, 24'd0);
        push_expect(1, "ring_end_time", SEL_TIME, 24'h070003);
        applyStimulus(4'd0, 1'b0, 1'b1);

        // Button cancels RING and is not routed
        arm_and_ring(24'h070004);
        push_expect(1, "btn_cancel_mode", SEL_MODE, 24'd0);
        push_expect(1, "btn_cancel_flag", SEL_RING, 24'd0);
        push_expect(1, "btn_cancel_tbtn", SEL_TBTN, 24'h0);
        push_expect(1, "btn_cancel_abtn", SEL_ABTN, 24'h0);
        applyStimulus(4'b0010, 1'b0, 1'b0);

        // Disarming cancels RING
        arm_and_ring(24'h070005);
        switch_alarm_enable = 1'b0;
        push_expect(1, "dis_cancel_mode", SEL_MODE, 24'd0);
        push_expect(1, "dis_cancel_flag", SEL_RING, 24'd0);
        push_expect(1, "dis_cancel_tbtn", SEL_TBTN, 24'h0);
        push_expect(1, "dis_cancel_abtn", SEL_ABTN, 24'h0);
        idle(1);
        switch_alarm_enable = 1'b1;

        // An edit switch pre-empts RING
        arm_and_ring(24'h070006);
        switch_set_alarm = 1'b1;
        push_expect(1, "sw_cancel_mode", SEL_MODE, 24'd2);
        push_expect(1, "sw_cancel_flag", SEL_RING, 24'd0);
        idle(1);
        switch_set_alarm = 1'b0;
        idle(1);

        // Asynchronous reset in the middle of RING
        arm_and_ring(24'h070007);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_flag",  SEL_RING,  24'd0);
        checkOutput("arst_mode",  SEL_MODE,  24'd0);
        checkOutput("arst_alarm", SEL_ALARM, 24'h070000);
        checkOutput("arst_time",  SEL_TIME,  24'h000000);
        checkOutput("arst_disp",  SEL_DISP,  24'h000000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            n_fail++;
            $display("[TB] FAIL %s: actual never-checked required %h", sb[0].name, sb[0].value);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
